// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder used as the only arithmetic element of the
// serial adder datapath.
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: on an accepted start, the operands and carry-in are
// captured, then one bit per cycle is summed LSB-first through a single
// full-adder cell. The result appears after WIDTH SHIFT cycles, with a
// one-cycle done pulse in DONE.
//
// Handshake: start is a request that is sampled only while IDLE (busy=0);
// starts seen in SHIFT or DONE are dropped, not queued. done is high for
// exactly one cycle, and sum_out/cout_out are valid from that cycle until the
// next start is accepted.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_sum;
  logic fa_carry;
  logic last_bit;

  assign last_bit = (cnt_q == LAST_CNT);

  full_adder_cell u_fa (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .Cin   (carry_q),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift and accumulate while in SHIFT.
  // The result registers are left alone otherwise so they hold after done.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        // Hold on the final bit so the counter never wraps.
        cnt_d   = last_bit ? cnt_q : cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // The carry flop holds the final carry once SHIFT completes.
  assign sum_out     = sum_q;
  assign cout_out    = carry_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance for directed and table
// vectors, plus a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 8-bit instance signals
  logic       start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  state_e     st8;

  // 4-bit instance signals
  logic       start4, cin4, cout4, busy4, done4;
  logic [3:0] a4, b4, sum4;
  state_e     st4;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .sum_out(sum8), .cout_out(cout8), .busy(busy8), .done(done8), .dbg_state_o(st8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin_in(cin4),
    .sum_out(sum4), .cout_out(cout4), .busy(busy4), .done(done4), .dbg_state_o(st4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] e8;
  logic [4:0] e4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop the expected {cout,sum} whenever the 8-bit DUT signals done.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done_cnt8++;
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected actual=done required=no_done at %0t", $time);
      end else begin
        e8 = exp8_q.pop_front();
        check("result8", 32'({cout8, sum8}), 32'(e8));
      end
    end
  end

  // Same for the 4-bit DUT.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected actual=done required=no_done at %0t", $time);
      end else begin
        e4 = exp4_q.pop_front();
        check("result4", 32'({cout4, sum4}), 32'(e4));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge while the DUT is IDLE; start is dropped on the next negedge.
  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [8:0] exp, input bit push);
    a8 = a;
    b8 = b;
    cin8 = c;
    start8 = 1'b1;
    if (push) exp8_q.push_back(exp);
  endtask

  // Returns the number of negedges from the start negedge to the done negedge.
  task automatic wait_done8(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (done8 === 1'b1) begin
        k = i;
        break;
      end
    end
    if (k < 0) begin
      checks++;
      errors++;
      $display("FAIL done8_timeout actual=no_done required=done at %0t", $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int dc0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Reset state, with start held high to show reset wins.
    repeat (3) @(negedge clk);
    check("rst_sum", 32'(sum8), 32'(0));
    check("rst_cout", 32'(cout8), 32'(0));
    check("rst_busy", 32'(busy8), 32'(0));
    check("rst_done", 32'(done8), 32'(0));
    check("rst_state", 32'(st8), 32'(IDLE));
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    check("rst_over_start_busy", 32'(busy8), 32'(0));
    check("rst_over_start_state", 32'(st8), 32'(IDLE));
    start8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: latency, result (scoreboard), and hold after done.
    for (int v = 0; v < 8; v++) begin
      start8_op(vecs[v].a, vecs[v].b, vecs[v].cin, {vecs[v].exp_cout, vecs[v].exp_sum}, 1'b1);
      wait_done8(k);
      check("latency8", 32'(k), 32'(9));
      @(negedge clk);
      check("hold8", 32'({cout8, sum8}), 32'({vecs[v].exp_cout, vecs[v].exp_sum}));
      check("idle_busy8", 32'(busy8), 32'(0));
    end

    // Start re-pulsed during SHIFT and during DONE must be ignored;
    // operand changes mid-run must not leak into the result.
    start8_op(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h96}, 1'b1);
    dc0 = done_cnt8;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (i == 3) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
      if (i == 9) begin
        check("ignore_done_at9", 32'(done8), 32'(1));
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    check("ignore_done_start_busy", 32'(busy8), 32'(0));
    repeat (12) @(negedge clk);
    check("ignore_done_count", 32'(done_cnt8 - dc0), 32'(1));
    check("ignore_hold", 32'({cout8, sum8}), 32'({1'b0, 8'h96}));

    // Back-to-back: start in the IDLE cycle right after done.
    start8_op(8'h12, 8'h34, 1'b0, {1'b0, 8'h46}, 1'b1);
    wait_done8(k);
    check("b2b_first_latency", 32'(k), 32'(9));
    @(negedge clk);
    check("b2b_hold", 32'({cout8, sum8}), 32'({1'b0, 8'h46}));
    start8_op(8'hC8, 8'h64, 1'b0, {1'b1, 8'h2C}, 1'b1);
    wait_done8(k);
    check("b2b_done_gap", 32'(k + 1), 32'(10));

    // Reset on the 4th SHIFT cycle aborts without a done pulse.
    @(negedge clk);
    start8_op(8'hAA, 8'h55, 1'b0, '0, 1'b0);
    dc0 = done_cnt8;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
    end
    check("abort_in_shift", 32'(st8), 32'(SHIFT));
    rst = 1'b1;
    @(negedge clk);
    check("abort_sum", 32'(sum8), 32'(0));
    check("abort_cout", 32'(cout8), 32'(0));
    check("abort_busy", 32'(busy8), 32'(0));
    check("abort_done", 32'(done8), 32'(0));
    check("abort_state", 32'(st8), 32'(IDLE));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt8 - dc0), 32'(0));
    check("abort_sum_idle", 32'(sum8), 32'(0));
    start8_op(8'h01, 8'h01, 1'b0, {1'b0, 8'h02}, 1'b1);
    wait_done8(k);
    check("post_abort_latency", 32'(k), 32'(9));

    // Exhaustive sweep on the 4-bit instance against a behavioural sum.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a4 = 4'(ia);
          b4 = 4'(ib);
          cin4 = 1'(ic);
          start4 = 1'b1;
          exp4_q.push_back(5'(ia + ib + ic));
          k = -1;
          for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start4 = 1'b0;
            if (done4 === 1'b1) begin
              k = i;
              break;
            end
          end
          check("latency4", 32'(k), 32'(5));
        end
      end
    end

    repeat (3) @(negedge clk);
    check("queue8_drained", 32'(exp8_q.size()), 32'(0));
    check("queue4_drained", 32'(exp4_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
